muldiv_unit: RTL and testbench

- Multi-cycle RV32M execute unit in the EX stage, directly downstream of decode.
- Consumes the decoded `is_muldiv` class (01 = multiply, 10 = divide/remainder), the `alu_op` select, and the two operands.
- Produces a 32-bit result with a one-cycle valid pulse.
- While a divide iterates, it stalls the pipeline through `busy_o`.

---
 rtl/muldiv_pkg.sv | 48 ++++
 rtl/muldiv_divider.sv | 76 +++++++
 rtl/muldiv_unit.sv | 217 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Also supplies the ALU op-select macros when no external definitions are present.
`ifndef ALU_OP_WIDTH
  `define ALU_OP_WIDTH 4
  `define ALU_MUL      4'h0
  `define ALU_MULH     4'h1
  `define ALU_MULSHU   4'h2
  `define ALU_MULHU    4'h3
  `define ALU_DIV      4'h4
  `define ALU_DIVU     4'h5
  `define ALU_REM      4'h6
  `define ALU_REMU     4'h7
`endif

package muldiv_pkg;
  localparam int MULDIV_XLEN = 32;
  localparam int OP_W        = `ALU_OP_WIDTH;

  localparam logic [MULDIV_XLEN-1:0] DIV_BY_ZERO_Q = '1;
  localparam logic [MULDIV_XLEN-1:0] INT_MIN       = 32'h8000_0000;

  localparam logic [1:0] CLS_MUL = 2'b01;
  localparam logic [1:0] CLS_DIV = 2'b10;

  localparam logic [OP_W-1:0] OP_MUL    = `ALU_MUL;
  localparam logic [OP_W-1:0] OP_MULH   = `ALU_MULH;
  localparam logic [OP_W-1:0] OP_MULSHU = `ALU_MULSHU;
  localparam logic [OP_W-1:0] OP_MULHU  = `ALU_MULHU;
  localparam logic [OP_W-1:0] OP_DIV    = `ALU_DIV;
  localparam logic [OP_W-1:0] OP_DIVU   = `ALU_DIVU;
  localparam logic [OP_W-1:0] OP_REM    = `ALU_REM;
  localparam logic [OP_W-1:0] OP_REMU   = `ALU_REMU;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} muldiv_state_e;

  // Only multiply and divide classes start an operation; 00 and 11 are ignored.
  function automatic logic is_muldiv_class(input logic [1:0] cls);
    return (cls == CLS_MUL) || (cls == CLS_DIV);
  endfunction

  function automatic logic op_div_signed(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [OP_W-1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction
endpackage

// File: rtl/muldiv_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// start_i loads operands; done_o is high in the cycle whose edge performs the last step,
// after which quotient_o/remainder_o hold the result until the next start.
module muldiv_divider
  import muldiv_pkg::*;
#(
  parameter int XLEN      = MULDIV_XLEN,
  parameter int DIV_CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);
  logic [XLEN-1:0]      quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 active_q, active_d;
  logic [XLEN:0]        rem_sh, diff;

  assign rem_sh      = {rem_q, quo_q[XLEN-1]};
  assign diff        = rem_sh - {1'b0, dsr_q};
  assign done_o      = active_q && (cnt_q == DIV_CNT_W'(XLEN - 1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  // Load on start, then shift-subtract; a negative trial difference restores the remainder.
  always_comb begin
    quo_d    = quo_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (kill_i) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (start_i) begin
      quo_d    = dividend_i;
      rem_d    = '0;
      dsr_d    = divisor_i;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (!diff[XLEN]) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
      if (done_o) active_d = 1'b0;
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// RV32M EX-stage multiply/divide unit: single-cycle multiply, iterative divide,
// special-case divides resolved directly in the FIX state.
// Optional: MULDIV_REM_FUSE_EN caches the last iterated divide so a matching
// DIV/REM pair only iterates once.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN      = MULDIV_XLEN,
  parameter int DIV_CNT_W = $clog2(XLEN) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic [1:0]               is_muldiv_i,
  input  logic [`ALU_OP_WIDTH-1:0] alu_op_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic                     flush_i,
  output logic                     ready_o,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic [XLEN-1:0]          result_o
);
  muldiv_state_e           state_q, state_d;
  logic [OP_W-1:0]         op_q, op_d;
  logic [XLEN-1:0]         a_q, a_d, b_q, b_d, result_q, result_d, fix_res_q, fix_res_d;
  logic                    q_neg_q, q_neg_d, r_neg_q, r_neg_d, direct_q, direct_d, valid_q, valid_d;

  logic                    accept, in_signed, in_rem, in_div0, in_ovf;
  logic [XLEN-1:0]         abs_a, abs_b, spec_res, q_fix, r_fix, div_quo, div_rem;
  logic                    div_start, div_done, cache_hit;
  logic [XLEN-1:0]         cache_res;

  logic [2*XLEN+1:0]       a_ext, b_ext, prod;
  logic [1:0]              prod_unused;
  logic [XLEN-1:0]         mul_res;

  assign ready_o  = (state_q == ST_IDLE);
  assign busy_o   = (state_q != ST_IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

  // Request decode, taken straight from the ID/EX inputs in the accept cycle.
  assign accept    = valid_i && ready_o && is_muldiv_class(is_muldiv_i) && !flush_i;
  assign in_signed = op_div_signed(alu_op_i);
  assign in_rem    = op_is_rem(alu_op_i);
  assign in_div0   = (operand_b_i == '0);
  assign in_ovf    = in_signed && (operand_a_i == INT_MIN) && (operand_b_i == DIV_BY_ZERO_Q);
  assign abs_a     = (in_signed && operand_a_i[XLEN-1]) ? -operand_a_i : operand_a_i;
  assign abs_b     = (in_signed && operand_b_i[XLEN-1]) ? -operand_b_i : operand_b_i;
  assign spec_res  = in_div0 ? (in_rem ? operand_a_i : DIV_BY_ZERO_Q)
                             : (in_rem ? '0 : INT_MIN);

  // Multiply on the latched operands; extension to 2*XLEN+2 covers every signedness mix.
  assign a_ext       = {{(XLEN+2){((op_q == OP_MULH) || (op_q == OP_MULSHU)) && a_q[XLEN-1]}}, a_q};
  assign b_ext       = {{(XLEN+2){(op_q == OP_MULH) && b_q[XLEN-1]}}, b_q};
  assign prod        = a_ext * b_ext;
  assign prod_unused = prod[2*XLEN+1:2*XLEN];
  assign mul_res     = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Sign fix-up of the unsigned divider result.
  assign q_fix = q_neg_q ? -div_quo : div_quo;
  assign r_fix = r_neg_q ? -div_rem : div_rem;

  muldiv_divider #(.XLEN(XLEN), .DIV_CNT_W(DIV_CNT_W)) u_div (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (div_start),
    .kill_i      (flush_i),
    .dividend_i  (abs_a),
    .divisor_i   (abs_b),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

`ifdef MULDIV_REM_FUSE_EN
  logic            cache_vld_q, cache_vld_d, cache_sgn_q, cache_sgn_d;
  logic [XLEN-1:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic [XLEN-1:0] cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;
  logic            fix_commit, mul_accept;

  assign fix_commit = (state_q == ST_FIX) && !flush_i && !direct_q;
  assign mul_accept = accept && (is_muldiv_i == CLS_MUL);
  assign cache_hit  = cache_vld_q && (cache_sgn_q == in_signed) &&
                      (cache_a_q == operand_a_i) && (cache_b_q == operand_b_i);
  assign cache_res  = in_rem ? cache_rem_q : cache_quo_q;

  // Capture both results of every iterated divide; drop them on flush or any multiply.
  always_comb begin
    cache_vld_d = cache_vld_q;
    cache_sgn_d = cache_sgn_q;
    cache_a_d   = cache_a_q;
    cache_b_d   = cache_b_q;
    cache_quo_d = cache_quo_q;
    cache_rem_d = cache_rem_q;
    if (fix_commit) begin
      cache_vld_d = 1'b1;
      cache_sgn_d = op_div_signed(op_q);
      cache_a_d   = a_q;
      cache_b_d   = b_q;
      cache_quo_d = q_fix;
      cache_rem_d = r_fix;
    end
    if (mul_accept || flush_i) cache_vld_d = 1'b0;
  end

  // Divide result cache registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cache_vld_q <= 1'b0;
      cache_sgn_q <= 1'b0;
      cache_a_q   <= '0;
      cache_b_q   <= '0;
      cache_quo_q <= '0;
      cache_rem_q <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_sgn_q <= cache_sgn_d;
      cache_a_q   <= cache_a_d;
      cache_b_q   <= cache_b_d;
      cache_quo_q <= cache_quo_d;
      cache_rem_q <= cache_rem_d;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  // FSM next state, operand latching and registered result/valid.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    direct_d  = direct_q;
    fix_res_d = fix_res_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    div_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = alu_op_i;
          a_d  = operand_a_i;
          b_d  = operand_b_i;
          if (is_muldiv_i == CLS_MUL) begin
            state_d = ST_MUL;
          end else if (in_div0 || in_ovf) begin
            fix_res_d = spec_res;
            direct_d  = 1'b1;
            state_d   = ST_FIX;
          end else if (cache_hit) begin
            fix_res_d = cache_res;
            direct_d  = 1'b1;
            state_d   = ST_FIX;
          end else begin
            q_neg_d   = in_signed && (operand_a_i[XLEN-1] ^ operand_b_i[XLEN-1]);
            r_neg_d   = in_signed && operand_a_i[XLEN-1];
            direct_d  = 1'b0;
            div_start = 1'b1;
            state_d   = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        state_d = ST_IDLE;
        if (!flush_i) begin
          result_d = mul_res;
          valid_d  = 1'b1;
        end
      end
      ST_DIV: begin
        if (flush_i)       state_d = ST_IDLE;
        else if (div_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush_i) begin
          result_d = direct_q ? fix_res_q : (op_is_rem(op_q) ? r_fix : q_fix);
          valid_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      direct_q  <= 1'b0;
      fix_res_q <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      direct_q  <= direct_d;
      fix_res_q <= fix_res_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases plus randomized ops against
// an arithmetic reference model. Latency is counted in clock edges: an op
// accepted at edge t has valid_o high right after edge t+1 (multiply/special/fused)
// or t+XLEN+1 (iterated divide), i.e. captured downstream at t+2 / t+XLEN+2.
module tb_muldiv_unit;
  import muldiv_pkg::*;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_i, valid_i, flush_i;
  logic [1:0]      is_muldiv_i;
  logic [OP_W-1:0] alu_op_i;
  logic [XLEN-1:0] operand_a_i, operand_b_i;
  logic            ready_o, busy_o, valid_o;
  logic [XLEN-1:0] result_o;

  muldiv_unit dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .is_muldiv_i (is_muldiv_i),
    .alu_op_i    (alu_op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .result_o    (result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] res;
    int              cyc;
    int              id;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int id_ctr = 0;

  // Reference model state for the optional result cache.
  bit              c_vld = 1'b0;
  bit              c_sgn = 1'b0;
  logic [XLEN-1:0] c_a = '0, c_b = '0;

  logic [OP_W-1:0] mul_ops [4] = '{OP_MUL, OP_MULH, OP_MULSHU, OP_MULHU};
  logic [OP_W-1:0] div_ops [4] = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] c, input logic [OP_W-1:0] o,
                                             input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, p, q, r;
    bit sgn, rem;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'h0, x};
    uy = {32'h0, y};
    if (c == CLS_MUL) begin
      if (o == OP_MUL || o == OP_MULH) p = sx * sy;
      else if (o == OP_MULSHU)         p = sx * uy;
      else                             p = ux * uy;
      return (o == OP_MUL) ? p[31:0] : p[63:32];
    end
    sgn = (o == OP_DIV) || (o == OP_REM);
    rem = (o == OP_REM) || (o == OP_REMU);
    if (y == 0) return rem ? x : 32'hFFFF_FFFF;
    if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sgn) begin q = sx / sy; r = sx % sy; end
    else     begin q = ux / uy; r = ux % uy; end
    return rem ? r[31:0] : q[31:0];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      4:       return 32'hFFFF_FFFF - $urandom_range(0, 20);
      default: return $urandom();
    endcase
  endfunction

  // Drive one request, wait for acceptance, and predict result and completion edge.
  task automatic issue(input logic [1:0] c, input logic [OP_W-1:0] o,
                       input logic [31:0] x, input logic [31:0] y, input bit expect_done);
    int n, lat, acc;
    bit is_div, sgn, special, hit;
    exp_t e;
    valid_i = 1'b1; is_muldiv_i = c; alu_op_i = o; operand_a_i = x; operand_b_i = y;
    n = 0;
    while (!ready_o && n < 200) begin @(negedge clk); n++; end
    if (!ready_o) check("ready_wait_timeout", 32'(ready_o), 32'd1);
    acc     = cyc + 1;
    is_div  = (c == CLS_DIV);
    sgn     = (o == OP_DIV) || (o == OP_REM);
    special = is_div && (y == 0 || (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    hit     = 1'b0;
`ifdef MULDIV_REM_FUSE_EN
    hit = is_div && !special && c_vld && (c_sgn == sgn) && (c_a == x) && (c_b == y);
`endif
    lat = (!is_div || special || hit) ? 1 : XLEN + 1;
    if (!is_div) c_vld = 1'b0;
    else if (!special && !hit && expect_done) begin
      c_vld = 1'b1; c_sgn = sgn; c_a = x; c_b = y;
    end
    if (expect_done) begin
      e.res = ref_result(c, o, x, y);
      e.cyc = acc + lat;
      e.id  = id_ctr++;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    operand_a_i = $urandom();
    operand_b_i = $urandom();
    alu_op_i    = div_ops[$urandom_range(0, 3)];
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || sb.size() != 0) && n < 200) begin @(negedge clk); n++; end
    check("idle_wait", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every valid_o pops the oldest prediction and checks value and timing.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i && valid_o) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_valid: got result %h expected no valid_o", result_o);
      end else begin
        e = sb.pop_front();
        check($sformatf("result_op%0d", e.id), result_o, e.res);
        check($sformatf("latency_op%0d", e.id), 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] x, y;
    logic [1:0] c;
    logic [OP_W-1:0] o;
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; is_muldiv_i = 2'b00;
    alu_op_i = OP_MUL; operand_a_i = '0; operand_b_i = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_busy",  32'(busy_o),  32'd0);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_result", result_o, 32'h0);
    rst_i = 1'b0;
    @(negedge clk);

    // Multiply, second one accepted in the first one's valid_o cycle.
    issue(CLS_MUL, OP_MUL,   32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
    issue(CLS_MUL, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(CLS_MUL, OP_MULH,  32'h8000_0000, 32'h8000_0000, 1'b1);
    issue(CLS_MUL, OP_MULSHU,32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_idle();

    // Iterated divide: busy for XLEN+1 cycles.
    issue(CLS_DIV, OP_DIV, 32'hFFFF_FFEC, 32'd3, 1'b1);
    n = 0;
    while (busy_o && n < 100) begin n++; @(negedge clk); end
    check("div_busy_cycles", 32'(n), 32'(XLEN + 1));
    issue(CLS_DIV, OP_REM,  32'hFFFF_FFEC, 32'd3, 1'b1);
    issue(CLS_DIV, OP_REMU, 32'd20, 32'd3, 1'b1);
    // Special cases.
    issue(CLS_DIV, OP_DIVU, 32'd5, 32'd0, 1'b1);
    issue(CLS_DIV, OP_REM,  32'd5, 32'd0, 1'b1);
    issue(CLS_DIV, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(CLS_DIV, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle();

    // Ignored class codes.
    valid_i = 1'b1; alu_op_i = OP_DIV; operand_a_i = 32'd9; operand_b_i = 32'd2;
    is_muldiv_i = 2'b00; @(negedge clk);
    check("ignore_cls00_busy", 32'(busy_o), 32'd0);
    is_muldiv_i = 2'b11; @(negedge clk);
    check("ignore_cls11_busy", 32'(busy_o), 32'd0);
    // Flush coincident with a request suppresses it.
    is_muldiv_i = CLS_MUL; alu_op_i = OP_MUL; flush_i = 1'b1; @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0; c_vld = 1'b0;
    check("flush_at_accept_busy", 32'(busy_o), 32'd0);

    // Flush 10 cycles into a divide.
    issue(CLS_DIV, OP_DIV, 32'd1000, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    flush_i = 1'b1; @(negedge clk); flush_i = 1'b0; c_vld = 1'b0;
    check("flush_ready", 32'(ready_o), 32'd1);
    check("flush_busy",  32'(busy_o),  32'd0);
    repeat (40) @(negedge clk);
    issue(CLS_MUL, OP_MUL, 32'd3, 32'd4, 1'b1);
    wait_idle();

    // Asynchronous reset in the middle of a divide.
    issue(CLS_DIV, OP_DIVU, 32'd12345, 32'd17, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_ready",  32'(ready_o), 32'd1);
    check("midrst_busy",   32'(busy_o),  32'd0);
    check("midrst_valid",  32'(valid_o), 32'd0);
    check("midrst_result", result_o, 32'h0);
    @(negedge clk); rst_i = 1'b0; c_vld = 1'b0;
    @(negedge clk);

    // Divide then remainder with identical operands, then a changed divisor.
    issue(CLS_DIV, OP_DIV, 32'd100, 32'd7, 1'b1);
    issue(CLS_DIV, OP_REM, 32'd100, 32'd7, 1'b1);
    issue(CLS_DIV, OP_REM, 32'd100, 32'd8, 1'b1);
    wait_idle();

    // Randomized traffic; some requests reuse the previous operands.
    x = 32'd1; y = 32'd1;
    for (int i = 0; i < 60; i++) begin
      c = ($urandom_range(0, 1) == 0) ? CLS_MUL : CLS_DIV;
      o = (c == CLS_MUL) ? mul_ops[$urandom_range(0, 3)] : div_ops[$urandom_range(0, 3)];
      if ($urandom_range(0, 2) != 0) begin x = pick(); y = pick(); end
      issue(c, o, x, y, 1'b1);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
